// File: rtl/execute_writeback_stage.sv
// Execute / memory / writeback datapath: forwarding muxes, ALU, data memory,
// 32-entry register file and the EX/MEM and MEM/WB pipeline registers.
module execute_writeback_stage #(
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ra_addr,
    input  logic [4:0]        rb_addr,
    input  logic [1:0]        mux_sel_a,
    input  logic [1:0]        mux_sel_b,
    input  logic              imm_sel,
    input  logic [7:0]        Imm,
    input  logic              mem_en_dec,
    input  logic              mem_rw_dec,
    input  logic              mem_mux_sel_dec,
    input  logic [4:0]        RW_dec,
    input  logic [4:0]        op_dec,
    output logic [DATA_W-1:0] alu_q,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] rf_q  [32];
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // EX/MEM
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] st_data_q;
    logic [4:0]        rw_m_q;
    logic              mem_en_q;
    logic              mem_rw_q;
    logic              mem_mux_q;
    logic              vld_m_q;

    // MEM/WB
    logic [DATA_W-1:0] wbv_q;
    logic [4:0]        rw_w_q;
    logic              we_w_q;
    logic              vld_w_q;

    logic [DATA_W-1:0] opa_d;
    logic [DATA_W-1:0] opb_d;
    logic [DATA_W-1:0] alu_res_d;
    logic [DATA_W-1:0] wbv_d;
    logic [AW-1:0]     mem_addr;

    function automatic logic [DATA_W-1:0] alu_f(input logic [4:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            5'b00000: r = a + b;
            5'b00001: r = a - b;
            5'b00010: r = a & b;
            5'b00011: r = a | b;
            5'b00100: r = a ^ b;
            5'b00101: r = ~a;
            5'b00110: r = a << b[3:0];
            5'b00111: r = a >> b[3:0];
            5'b01000: r = b;
            default:  r = a;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_f(input logic [1:0] sel,
                                                 input logic [DATA_W-1:0] rf_val,
                                                 input logic [DATA_W-1:0] exm_val,
                                                 input logic [DATA_W-1:0] mwb_val);
        logic [DATA_W-1:0] r;
        case (sel)
            2'b01:   r = exm_val;
            2'b10:   r = mwb_val;
            default: r = rf_val;
        endcase
        return r;
    endfunction

    assign mem_addr = alu_res_q[AW-1:0];

    always_comb begin
        opa_d = fwd_f(mux_sel_a, rf_q[ra_addr], alu_res_q, wbv_q);
        opb_d = fwd_f(mux_sel_b, rf_q[rb_addr], alu_res_q, wbv_q);
        if (imm_sel) begin
            opb_d = {{(DATA_W-8){1'b0}}, Imm};
        end
        alu_res_d = alu_f(op_dec, opa_d, opb_d);
        // Registered into wbv_q below, so this behaves as a synchronous read
        wbv_d = mem_mux_q ? mem_q[mem_addr] : alu_res_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_res_q <= '0;
            st_data_q <= '0;
            rw_m_q    <= '0;
            mem_en_q  <= 1'b0;
            mem_rw_q  <= 1'b0;
            mem_mux_q <= 1'b0;
            vld_m_q   <= 1'b0;
            wbv_q     <= '0;
            rw_w_q    <= '0;
            we_w_q    <= 1'b0;
            vld_w_q   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            alu_res_q <= alu_res_d;
            st_data_q <= opa_d;
            rw_m_q    <= RW_dec;
            mem_en_q  <= mem_en_dec;
            mem_rw_q  <= mem_rw_dec;
            mem_mux_q <= mem_mux_sel_dec;
            vld_m_q   <= 1'b1;
            wbv_q     <= wbv_d;
            rw_w_q    <= rw_m_q;
            we_w_q    <= ~(mem_en_q & mem_rw_q);
            vld_w_q   <= vld_m_q;
            if (wb_en) begin
                rf_q[wb_addr] <= wb_data;
            end
        end
    end

    // Data memory keeps its contents across reset; an in-flight store is dropped
    always_ff @(posedge clk) begin
        if (!reset && mem_en_q && mem_rw_q) begin
            mem_q[mem_addr] <= st_data_q;
        end
    end

    assign alu_q   = alu_res_q;
    assign wb_en   = vld_w_q & we_w_q;
    assign wb_addr = rw_w_q;
    assign wb_data = wbv_q;

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Scoreboard bench for execute_writeback_stage: directed sequences plus random
// instructions, checked against an instruction-level reference model.
module tb_execute_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ra_addr = '0, rb_addr = '0, RW_dec = '0, op_dec = '0;
    logic [1:0]  mux_sel_a = '0, mux_sel_b = '0;
    logic        imm_sel = 1'b0, mem_en_dec = 1'b0, mem_rw_dec = 1'b0, mem_mux_sel_dec = 1'b0;
    logic [7:0]  Imm = '0;
    logic [15:0] alu_q, wb_data;
    logic        wb_en;
    logic [4:0]  wb_addr;

    execute_writeback_stage #(.DATA_W(16), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b), .imm_sel(imm_sel), .Imm(Imm),
        .mem_en_dec(mem_en_dec), .mem_rw_dec(mem_rw_dec), .mem_mux_sel_dec(mem_mux_sel_dec),
        .RW_dec(RW_dec), .op_dec(op_dec), .alu_q(alu_q), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [15:0] data; } alu_t;
    typedef struct { int due; logic en; logic [4:0] addr; logic [15:0] data; } wb_t;
    alu_t alu_sb[$];
    wb_t  wb_sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 0;
    bit fin_req = 0;
    bit fin_done = 0;

    // Reference model: architectural state at instruction granularity
    logic [15:0] mreg [32];
    logic [15:0] mmem [256];
    bit          mwr  [256];
    logic [7:0]  wr_addrs[$];
    logic [15:0] h_alu[$], h_fin[$];
    bit          h_we[$];
    logic [4:0]  h_rw[$];
    int          n = 0;
    bit          pend_st = 0;
    logic [7:0]  pend_addr;
    logic [15:0] pend_data;

    function automatic logic [15:0] ref_alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        int ia, ib, sh;
        ia = int'(a);
        ib = int'(b);
        sh = int'(b) % 16;
        case (op)
            5'd0: return 16'((ia + ib) % 65536);
            5'd1: return 16'((ia - ib + 65536) % 65536);
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return a ^ b;
            5'd5: return 16'(65535 - ia);
            5'd6: return 16'((ia * (1 << sh)) % 65536);
            5'd7: return 16'(ia / (1 << sh));
            5'd8: return b;
            default: return a;
        endcase
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [4:0] r);
        if (sel == 2'b01) return (n >= 1) ? h_alu[n-1] : 16'h0000;
        if (sel == 2'b10) return (n >= 2) ? h_fin[n-2] : 16'h0000;
        return mreg[r];
    endfunction

    task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] sa,
                         input logic [1:0] sb, input logic is, input logic [7:0] imm,
                         input logic men, input logic mrw, input logic mms,
                         input logic [4:0] rw, input logic [4:0] op, input int exp_alu = -1);
        logic [15:0] a, b, res, fin, chk;
        bit we;
        int cur;
        @(posedge clk); #1;
        reset = 1'b0;
        ra_addr = ra; rb_addr = rb; mux_sel_a = sa; mux_sel_b = sb; imm_sel = is; Imm = imm;
        mem_en_dec = men; mem_rw_dec = mrw; mem_mux_sel_dec = mms; RW_dec = rw; op_dec = op;
        cur = cyc;
        if (n >= 3 && h_we[n-3]) mreg[h_rw[n-3]] = h_fin[n-3];
        if (pend_st) begin
            mmem[pend_addr] = pend_data;
            if (!mwr[pend_addr]) wr_addrs.push_back(pend_addr);
            mwr[pend_addr] = 1'b1;
            pend_st = 0;
        end
        a = pick(sa, ra);
        b = is ? {8'h00, imm} : pick(sb, rb);
        res = ref_alu(op, a, b);
        chk = (exp_alu >= 0) ? exp_alu[15:0] : res;
        we = !(men && mrw);
        if (men && mrw) begin
            pend_st = 1; pend_addr = res[7:0]; pend_data = a;
        end
        fin = mms ? mmem[res[7:0]] : res;
        alu_sb.push_back('{cur + 1, chk});
        wb_sb.push_back('{cur + 2, we, rw, fin});
        h_alu.push_back(res); h_fin.push_back(fin); h_we.push_back(we); h_rw.push_back(rw);
        n++;
    endtask

    task automatic do_reset();
        int cur;
        @(posedge clk); #1;
        reset = 1'b1;
        cur = cyc;
        while (alu_sb.size() > 0 && alu_sb[alu_sb.size()-1].due > cur) void'(alu_sb.pop_back());
        while (wb_sb.size() > 0 && wb_sb[wb_sb.size()-1].due > cur) void'(wb_sb.pop_back());
        alu_sb.push_back('{cur + 1, 16'h0000});
        alu_sb.push_back('{cur + 2, 16'h0000});
        wb_sb.push_back('{cur + 1, 1'b0, 5'd0, 16'h0000});
        wb_sb.push_back('{cur + 2, 1'b0, 5'd0, 16'h0000});
        @(posedge clk); #1;
        n = 0; pend_st = 0;
        h_alu.delete(); h_fin.delete(); h_we.delete(); h_rw.delete();
        for (int i = 0; i < 32; i++) mreg[i] = 16'h0000;
    endtask

    // Monitor: pops expectations when they fall due and compares DUT outputs
    alu_t ea;
    wb_t  ew;
    always @(negedge clk) begin
        if (mon_on) begin
            if (alu_sb.size() > 0 && alu_sb[0].due == cyc) begin
                ea = alu_sb.pop_front();
                n_cmp++;
                if (alu_q !== ea.data) begin
                    n_bad++;
                    $display("FAIL alu_q cyc=%0d got=%h exp=%h", cyc, alu_q, ea.data);
                end
            end
            if (wb_sb.size() > 0 && wb_sb[0].due == cyc) begin
                ew = wb_sb.pop_front();
                n_cmp++;
                if (wb_en !== ew.en || (ew.en && (wb_addr !== ew.addr || wb_data !== ew.data))) begin
                    n_bad++;
                    $display("FAIL wb cyc=%0d got en=%b addr=%0d data=%h exp en=%b addr=%0d data=%h",
                             cyc, wb_en, wb_addr, wb_data, ew.en, ew.addr, ew.data);
                end
            end else if (wb_en === 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_spurious cyc=%0d got en=1 addr=%0d exp en=0", cyc, wb_addr);
            end
            if (fin_req && !fin_done) begin
                n_cmp++;
                if (alu_sb.size() != 0 || wb_sb.size() != 0) begin
                    n_bad++;
                    $display("FAIL drain got alu_left=%0d wb_left=%0d exp 0/0", alu_sb.size(), wb_sb.size());
                end
                fin_done = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ra, rb, rw, op;
        logic [1:0] sa, sb;
        logic [7:0] imm;
        logic       is;
        int         kind;
        for (int i = 0; i < 256; i++) begin mmem[i] = 16'h0000; mwr[i] = 0; end
        do_reset();
        mon_on = 1;

        // ADD imm chain with EX/MEM forward
        issue(0, 0, 2'b00, 2'b00, 1, 8'd5, 0, 0, 0, 5'd1, 5'd0, 16'h0005);
        issue(0, 0, 2'b01, 2'b00, 1, 8'd3, 0, 0, 0, 5'd2, 5'd0, 16'h0008);
        // MEM/WB forward
        issue(0, 0, 2'b00, 2'b00, 1, 8'hF0, 0, 0, 0, 5'd3, 5'd0, 16'h00F0);
        issue(0, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 0, 5'd4, 5'd31, 16'h0000);
        issue(0, 0, 2'b10, 2'b00, 1, 8'hFF, 0, 0, 0, 5'd5, 5'd4, 16'h000F);
        // Build 0x1234, store at 0x10, load back into R7
        issue(0, 0, 2'b00, 2'b00, 1, 8'h12, 0, 0, 0, 5'd6, 5'd0, 16'h0012);
        issue(0, 0, 2'b01, 2'b00, 1, 8'd8, 0, 0, 0, 5'd6, 5'd6, 16'h1200);
        issue(0, 0, 2'b01, 2'b00, 1, 8'h34, 0, 0, 0, 5'd6, 5'd3, 16'h1234);
        issue(0, 0, 2'b01, 2'b00, 1, 8'h10, 1, 1, 0, 5'd11, 5'd8, 16'h0010);
        issue(0, 0, 2'b00, 2'b00, 1, 8'h10, 1, 0, 1, 5'd7, 5'd8, 16'h0010);
        // Wrap and shift edges, undefined opcode
        issue(0, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 0, 5'd8, 5'd5, 16'hFFFF);
        issue(0, 0, 2'b01, 2'b00, 1, 8'd1, 0, 0, 0, 5'd12, 5'd0, 16'h0000);
        issue(0, 0, 2'b00, 2'b00, 1, 8'd1, 0, 0, 0, 5'd10, 5'd0, 16'h0001);
        issue(0, 0, 2'b01, 2'b00, 1, 8'd15, 0, 0, 0, 5'd13, 5'd6, 16'h8000);
        issue(0, 0, 2'b01, 2'b00, 1, 8'd15, 0, 0, 0, 5'd14, 5'd7, 16'h0001);
        issue(0, 0, 2'b01, 2'b00, 1, 8'd9, 0, 0, 0, 5'd15, 5'd31, 16'h0001);
        // Same destination twice; the later value must stick
        issue(0, 0, 2'b00, 2'b00, 1, 8'h11, 0, 0, 0, 5'd9, 5'd0, 16'h0011);
        issue(0, 0, 2'b00, 2'b00, 1, 8'h22, 0, 0, 0, 5'd9, 5'd0, 16'h0022);
        issue(0, 0, 2'b00, 2'b00, 1, 8'h00, 0, 0, 0, 5'd0, 5'd0, 16'h0000);
        issue(0, 0, 2'b00, 2'b00, 1, 8'h00, 0, 0, 0, 5'd0, 5'd0, 16'h0000);
        issue(9, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 0, 5'd0, 5'd31, 16'h0022);
        issue(7, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 0, 5'd0, 5'd31, 16'h1234);

        // Reset mid-stream, then every register must read back zero
        do_reset();
        for (int r = 0; r < 32; r++) begin
            issue(5'(r), 0, 2'b00, 2'b00, 0, 8'h00, 0, 0, 0, 5'd0, 5'd31, 16'h0000);
        end
        // Memory survives reset
        issue(0, 0, 2'b00, 2'b00, 1, 8'h10, 1, 0, 1, 5'd1, 5'd8, 16'h0010);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
                continue;
            end
            ra = 5'($urandom); rb = 5'($urandom); rw = 5'($urandom);
            sa = 2'($urandom); sb = 2'($urandom); is = 1'($urandom); imm = 8'($urandom);
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
            kind = $urandom_range(0, 9);
            if (kind == 0 && wr_addrs.size() > 0) begin
                imm = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                issue(ra, rb, sa, 2'b00, 1, imm, 1, 0, 1, rw, 5'd8);
            end else if (kind == 1) begin
                issue(ra, rb, sa, sb, is, imm, 1, 1, 0, rw, op);
            end else begin
                issue(ra, rb, sa, sb, is, imm, kind == 2, 0, 0, rw, op);
            end
        end
        for (int k = 0; k < 3; k++) issue(0, 0, 2'b00, 2'b00, 1, 8'h00, 0, 0, 0, 5'd0, 5'd0);

        @(posedge clk); @(posedge clk); #1;
        fin_req = 1;
        @(negedge clk); #1;
        if (!fin_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_check got not_run exp run");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/execute_writeback_stage.md
Name: execute_writeback_stage

Overview:
- Datapath stage directly downstream of Dependency_check; consumes its decoded controls and forwarding selects each cycle.
- Pipeline: EX (operand select + ALU) -> MEM (data memory) -> WB (register file write). One instruction accepted per clk, no stall.
- Contains the 32-entry register file, forwarding muxes, ALU, data memory and pipeline registers.

Parameters:
DATA_W, 16, datapath/register width
MEM_DEPTH, 256, data memory words (address = low 8 bits)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ra_addr  in  5  source register A of instruction in EX
rb_addr  in  5  source register B of instruction in EX
mux_sel_a  in  2  operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB value, 11 regfile
mux_sel_b  in  2  operand B source, same encoding
imm_sel  in  1  1: operand B = zero-extended Imm (overrides mux_sel_b)
Imm  in  8  immediate
mem_en_dec  in  1  memory access enable
mem_rw_dec  in  1  1 store, 0 load
mem_mux_sel_dec  in  1  WB source: 0 ALU, 1 memory read data
RW_dec  in  5  destination register
op_dec  in  5  ALU opcode
alu_q  out  DATA_W  EX/MEM ALU result register
wb_en  out  1  register write occurring this cycle
wb_addr  out  5  register being written
wb_data  out  DATA_W  value being written

Behaviour:
- Reset: all pipeline registers cleared, all valid bits 0, all 32 registers = 0. alu_q=0, wb_en=0, wb_addr=0, wb_data=0. Data memory not cleared. Reset overrides everything; instructions in flight are discarded.
- First cycle after reset deassertion: EX inputs are a valid instruction. Every cycle with reset=0 is an instruction; no bubble input exists.
- EX (combinational, cycle n):
  - opA and opB selected per mux_sel; then imm_sel applies to B.
  - ALU by op_dec: 00000 ADD, 00001 SUB (A-B), 00010 AND, 00011 OR, 00100 XOR, 00101 NOT A, 00110 SHL A by B[3:0], 00111 SHR logical A by B[3:0], 01000 pass B. Any other code passes A.
  - Results truncated to DATA_W; no flags.
- Edge 1 (EX/MEM):
  - Latch alu result into alu_q.
  - Latch opA as store data, plus RW, mem_en, mem_rw, mem_mux_sel and valid=1.
  - reg_we = NOT(mem_en AND mem_rw).
- Edge 2 (MEM/WB):
  - mem_en=1, mem_rw=1: mem[alu_q[7:0]] <= store data.
  - mem_en=1, mem_rw=0: synchronous read of mem[alu_q[7:0]].
  - MEM/WB value = read data if mem_mux_sel=1, else alu_q.
  - mem_mux_sel=1 with mem_en=0 yields undefined data; this is not required to be handled.
  - Latch RW and reg_we.
- WB (cycle n+2):
  - wb_en = valid AND reg_we; wb_addr, wb_data driven from MEM/WB.
  - Edge 3: regfile[wb_addr] <= wb_data when wb_en.
  - R0 is an ordinary register.
- Forwarding:
  - sel 01 returns instruction i-1 ALU result (alu_q), including the address of a load. Load-use stalling is upstream's responsibility.
  - sel 10 returns instruction i-2 final value (MEM/WB), including load data.
  - Instruction i-3 is already in the regfile, so no write-through bypass exists.
- Regfile reads are combinational. ra_addr==rb_addr is legal.
- Latency: alu_q valid 1 cycle after EX. wb_en pulses 2 cycles after EX. Register updated at the 3rd edge.
- Back-to-back writes to the same RW: the later instruction wins. A store and a load to the same address in consecutive instructions: the load sees the stored data because the write occurs at the earlier edge.

Test Plan:
- Reset: assert reset 2 cycles mid-stream -> alu_q=0, wb_en=0 next edge; read R1..R31 via pass-A op, sel 00 -> all 0.
- ADD imm chain: R1=R0+Imm 5 (op 00000, imm_sel=1, RW=1); next R2=R1+3 with mux_sel_a=01 -> alu_q=5 then 8; wb writes R1=5, R2=8 on consecutive cycles.
- MEM/WB forward: R3=0x00F0 via imm; NOP-like pass to R4; then R5=R3 XOR Imm 0xFF with mux_sel_a=10 -> alu_q=0x000F.
- Store/load: R6=0x1234; store opA=R6 at address Imm 0x10 (pass B, mem_en=1, mem_rw=1) -> wb_en=0; then load from 0x10 to R7 (mem_mux_sel=1) -> wb_data=0x1234, wb_addr=7.
- Shifts/wrap: R8=0xFFFF (NOT R0); ADD R8+1 -> alu_q=0x0000; SHL 0x0001 by 15 -> 0x8000; SHR 0x8000 by 15 -> 0x0001; undefined op 11111 -> A.
- Same-destination: two consecutive writes to R9 (0x11 then 0x22) -> R9 reads 0x22 three cycles later.
